// File: rtl/mrma_rr_if.sv
// rtl/mrma_rr_if.sv - client/resource handshake bundle for the mrma_rr match arbiter
interface mrma_rr_if #(
    parameter int N = 4,
    parameter int M = 4
);
    logic [N-1:0]   c;
    logic [N-1:0]   ca;
    logic [M-1:0]   r;
    logic [M-1:0]   ra;
    logic [M*N-1:0] cfg;

    modport master (output c, output r, input ca, input ra, input cfg);
    modport slave  (input c, input r, output ca, output ra, output cfg);
endinterface

// File: rtl/mrma_rr.sv
// rtl/mrma_rr.sv - round-robin multi-resource match arbiter holding one-hot client/resource matches
// Optional MRMA_MULTI_MATCH_EN: up to min(N,M) new matches per cycle instead of one.
module mrma_rr #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic        clk,
    input  logic        rst,
    mrma_rr_if.slave    bus
);
    localparam int CPW = (N > 1) ? $clog2(N) : 1;
    localparam int RPW = (M > 1) ? $clog2(M) : 1;
    localparam int MN  = M * N;
`ifdef MRMA_MULTI_MATCH_EN
    localparam int NPASS = (N < M) ? N : M;
`else
    localparam int NPASS = 1;
`endif

    logic [MN-1:0]  r_cfg;
    logic [CPW-1:0] r_cptr;
    logic [RPW-1:0] r_rptr;

    logic [N-1:0]   w_ca;
    logic [N-1:0]   w_cm;
    logic [N-1:0]   w_rel;
    logic [M-1:0]   w_ra;
    logic [M-1:0]   w_rm;
    logic [MN-1:0]  w_keep;
    logic [MN-1:0]  w_grant;
    logic [CPW-1:0] w_cptr_nxt;
    logic [RPW-1:0] w_rptr_nxt;

    for (genvar j = 0; j < N; j++) begin : g_col
        logic [M-1:0] w_col;
        for (genvar i = 0; i < M; i++) begin : g_cell
            assign w_col[i]         = r_cfg[i*N+j];
            assign w_keep[i*N+j]    = ~w_rel[j];
        end
        assign w_ca[j] = |w_col;
    end

    for (genvar i = 0; i < M; i++) begin : g_row
        assign w_ra[i] = |r_cfg[i*N +: N];
    end

    assign w_cm  = bus.c & ~w_ca;
    assign w_rm  = bus.r & ~w_ra;
    assign w_rel = ~bus.c & w_ca;

    // First set bit at or after ptr, cyclically; -1 when the mask is empty.
    function automatic int pick_c(input logic [N-1:0] mask, input int ptr);
        int           idx;
        int           res;
        logic [N-1:0] sh;
        res = -1;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + k;
            if (idx >= N) idx = idx - N;
            sh = mask >> idx;
            if (sh[0]) res = idx;
        end
        return res;
    endfunction

    function automatic int pick_r(input logic [M-1:0] mask, input int ptr);
        int           idx;
        int           res;
        logic [M-1:0] sh;
        res = -1;
        for (int k = M - 1; k >= 0; k--) begin
            idx = ptr + k;
            if (idx >= M) idx = idx - M;
            sh = mask >> idx;
            if (sh[0]) res = idx;
        end
        return res;
    endfunction

    // Released resources still show ra=1 here, so a grant can never land on one.
    always_comb begin
        int           gj;
        int           gi;
        logic [N-1:0] cl;
        logic [M-1:0] rl;
        w_grant    = '0;
        w_cptr_nxt = r_cptr;
        w_rptr_nxt = r_rptr;
        cl         = w_cm;
        rl         = w_rm;
        gj         = 0;
        gi         = 0;
        for (int p = 0; p < NPASS; p++) begin
            gj = pick_c(cl, int'(r_cptr));
            gi = pick_r(rl, int'(r_rptr));
            if (gj >= 0 && gi >= 0) begin
                w_grant    = w_grant | (MN'(1) << (gi * N + gj));
                cl         = cl & ~(N'(1) << gj);
                rl         = rl & ~(M'(1) << gi);
                w_cptr_nxt = CPW'((gj + 1 >= N) ? 0 : gj + 1);
                w_rptr_nxt = RPW'((gi + 1 >= M) ? 0 : gi + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg  <= '0;
            r_cptr <= '0;
            r_rptr <= '0;
        end else begin
            r_cfg  <= (r_cfg & w_keep) | w_grant;
            r_cptr <= w_cptr_nxt;
            r_rptr <= w_rptr_nxt;
        end
    end

    assign bus.ca  = w_ca;
    assign bus.ra  = w_ra;
    assign bus.cfg = r_cfg;
endmodule

// File: tb/tb_mrma_rr.sv
// tb/tb_mrma_rr.sv - self-checking bench for mrma_rr: vector table, corner sequences, random vs model
module tb_mrma_rr;
    localparam int TN = 4;
    localparam int TM = 2;
`ifdef MRMA_MULTI_MATCH_EN
    localparam int TP = (TN < TM) ? TN : TM;
`else
    localparam int TP = 1;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mrma_rr_if #(.N(TN), .M(TM)) bus ();

    mrma_rr #(.N(TN), .M(TM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [3:0]  c;
        logic [1:0]  r;
        logic [3:0]  ca;
        logic [1:0]  ra;
        logic [7:0]  cfg;
    } vec_t;

    // Reference: per-client owned resource (-1 = none) and the two pointers.
    int m_own [TN];
    int m_cp;
    int m_rp;

    task automatic model_reset();
        for (int j = 0; j < TN; j++) m_own[j] = -1;
        m_cp = 0;
        m_rp = 0;
    endtask

    task automatic model_step(input logic [TN-1:0] cv, input logic [TM-1:0] rv);
        bit cel [TN];
        bit rel [TM];
        int nown [TN];
        int gj, gi, lc, lr;
        bit got;
        for (int i = 0; i < TM; i++) rel[i] = rv[i];
        for (int j = 0; j < TN; j++) begin
            cel[j]  = cv[j] && (m_own[j] < 0);
            nown[j] = m_own[j];
            if (m_own[j] >= 0) rel[m_own[j]] = 1'b0;
            if (m_own[j] >= 0 && !cv[j]) nown[j] = -1;
        end
        got = 1'b0;
        lc  = 0;
        lr  = 0;
        for (int p = 0; p < TP; p++) begin
            gj = -1;
            gi = -1;
            for (int k = 0; k < TN; k++)
                if (gj < 0 && cel[(m_cp + k) % TN]) gj = (m_cp + k) % TN;
            for (int k = 0; k < TM; k++)
                if (gi < 0 && rel[(m_rp + k) % TM]) gi = (m_rp + k) % TM;
            if (gj >= 0 && gi >= 0) begin
                nown[gj] = gi;
                cel[gj]  = 1'b0;
                rel[gi]  = 1'b0;
                lc       = gj;
                lr       = gi;
                got      = 1'b1;
            end
        end
        if (got) begin
            m_cp = (lc + 1) % TN;
            m_rp = (lr + 1) % TM;
        end
        for (int j = 0; j < TN; j++) m_own[j] = nown[j];
    endtask

    function automatic logic [7:0] model_cfg();
        logic [7:0] v;
        v = '0;
        for (int j = 0; j < TN; j++)
            if (m_own[j] >= 0) v[m_own[j] * TN + j] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_onehot(input string name);
        logic [7:0] cf;
        bit         ok;
        cf = bus.cfg;
        ok = 1'b1;
        for (int i = 0; i < TM; i++)
            if ($countones(cf[i*TN +: TN]) > 1) ok = 1'b0;
        for (int j = 0; j < TN; j++)
            if ($countones({cf[TN+j], cf[j]}) > 1) ok = 1'b0;
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic apply_reset(input string name);
        rst   = 1'b1;
        bus.c = '0;
        bus.r = '0;
        #1;
        chk(name, {18'd0, bus.ca, bus.ra, bus.cfg}, 32'd0);
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    vec_t tbl [18];
    int   order_exp [5];

    initial begin
        int who;
        int wait_n;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.c  = '0;
        bus.r  = '0;
        model_reset();
        #12;

`ifndef MRMA_MULTI_MATCH_EN
        tbl[0]  = '{1'b1, 4'b0000, 2'b00, 4'b0000, 2'b00, 8'h00};
        tbl[1]  = '{1'b0, 4'b0001, 2'b11, 4'b0001, 2'b01, 8'b0000_0001};
        tbl[2]  = '{1'b0, 4'b0000, 2'b11, 4'b0000, 2'b00, 8'h00};
        tbl[3]  = '{1'b1, 4'b0000, 2'b00, 4'b0000, 2'b00, 8'h00};
        tbl[4]  = '{1'b0, 4'b1111, 2'b11, 4'b0001, 2'b01, 8'b0000_0001};
        tbl[5]  = '{1'b0, 4'b1111, 2'b11, 4'b0011, 2'b11, 8'b0010_0001};
        tbl[6]  = '{1'b0, 4'b1111, 2'b11, 4'b0011, 2'b11, 8'b0010_0001};
        tbl[7]  = '{1'b0, 4'b1110, 2'b11, 4'b0010, 2'b10, 8'b0010_0000};
        tbl[8]  = '{1'b0, 4'b1110, 2'b11, 4'b0110, 2'b11, 8'b0010_0100};
        tbl[9]  = '{1'b0, 4'b1100, 2'b10, 4'b0100, 2'b01, 8'b0000_0100};
        tbl[10] = '{1'b0, 4'b1100, 2'b10, 4'b1100, 2'b11, 8'b1000_0100};
        tbl[11] = '{1'b0, 4'b1000, 2'b11, 4'b1000, 2'b10, 8'b1000_0000};
        tbl[12] = '{1'b0, 4'b1010, 2'b11, 4'b1010, 2'b11, 8'b1000_0010};
        tbl[13] = '{1'b1, 4'b0000, 2'b00, 4'b0000, 2'b00, 8'h00};
        tbl[14] = '{1'b0, 4'b1111, 2'b11, 4'b0001, 2'b01, 8'b0000_0001};
        tbl[15] = '{1'b0, 4'b1111, 2'b00, 4'b0001, 2'b01, 8'b0000_0001};
        tbl[16] = '{1'b0, 4'b1110, 2'b00, 4'b0000, 2'b00, 8'h00};
        tbl[17] = '{1'b0, 4'b0000, 2'b11, 4'b0000, 2'b00, 8'h00};

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst) begin
                apply_reset($sformatf("vec%0d_async_rst", i));
            end else begin
                bus.c = tbl[i].c;
                bus.r = tbl[i].r;
                tick();
                chk($sformatf("vec%0d_ca_ra_cfg", i),
                    {18'd0, bus.ca, bus.ra, bus.cfg},
                    {18'd0, tbl[i].ca, tbl[i].ra, tbl[i].cfg});
            end
        end

        // Single usable resource: each client releases two cycles after ack and re-requests.
        order_exp = '{0, 1, 2, 3, 0};
        apply_reset("fair_rst");
        bus.c = 4'b1111;
        bus.r = 2'b01;
        for (int g = 0; g < 5; g++) begin
            wait_n = 0;
            do begin
                tick();
                wait_n++;
            end while (bus.ca == '0 && wait_n < 12);
            if (bus.ca == '0) begin
                chk($sformatf("fair_timeout%0d", g), 32'd0, 32'd1);
            end else begin
                who = -1;
                for (int j = 0; j < TN; j++) if (bus.ca[j]) who = j;
                chk($sformatf("fair_order%0d", g), who, order_exp[g]);
                chk($sformatf("fair_wait%0d", g), {31'd0, wait_n > 1 && g == 0}, 32'd0);
                tick();
                bus.c[who] = 1'b0;
                tick();
                chk($sformatf("fair_release%0d", g), {28'd0, bus.ca}, 32'd0);
                bus.c[who] = 1'b1;
            end
        end
`else
        apply_reset("mm_rst");
        bus.c = 4'b1111;
        bus.r = 2'b11;
        tick();
        chk("mm_diag", {24'd0, bus.cfg}, {24'd0, 8'b0010_0001});
        chk_onehot("mm_onehot");
`endif

        apply_reset("rand_rst");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                apply_reset($sformatf("rand_async_rst%0d", cyc));
            end else begin
                for (int j = 0; j < TN; j++)
                    if ($urandom_range(0, 3) == 0) bus.c[j] = ~bus.c[j];
                for (int i = 0; i < TM; i++)
                    bus.r[i] = ($urandom_range(0, 3) != 0);
                model_step(bus.c, bus.r);
                tick();
                chk($sformatf("rand%0d_cfg", cyc), {24'd0, bus.cfg}, {24'd0, model_cfg()});
                chk_onehot($sformatf("rand%0d_onehot", cyc));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
